// File: rtl/collatz_ctrl.sv
// Collatz sequence controller: sequences an external k/r datapath until k reaches 1.
// Optional step-limit abort is built only when COLLATZ_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for st
// LOAD  | clear step count, load seed into k and r
// CHECK | decide terminate / abort / next step kind
// EVEN  | halve k, count step
// ODD   | k <- 3k+1, count step
// DONE  | run finished, hold until st drops
// ERR   | run aborted, hold until st drops
module collatz_ctrl #(
  parameter int MAX_STEPS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [19:0] k,
  input  logic        r,
  output logic        Rx,
  output logic        Mx,
  output logic        Sk,
  output logic        Pk,
  output logic        Ik,
  output logic        Ir,
  output logic        Pr,
  output logic        Mr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    EVEN,
    ODD,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] step_cnt;
  logic        timeout;

`ifdef COLLATZ_TIMEOUT_EN
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);
  assign timeout = (step_cnt == STEP_LIMIT) && (k != 20'd1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating step counter: holds at 0xFFFF rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= 16'd0;
    end else if (state == LOAD) begin
      step_cnt <= 16'd0;
    end else if ((state == EVEN || state == ODD) && step_cnt != 16'hFFFF) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    Rx   = 1'b0;
    Mx   = 1'b0;
    Sk   = 1'b0;
    Pk   = 1'b0;
    Ik   = 1'b0;
    Ir   = 1'b0;
    Pr   = 1'b0;
    Mr   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (state)
      IDLE: begin
        if (st) state_nxt = LOAD;
      end
      LOAD: begin
        Rx = 1'b1;
        Sk = 1'b1;
        Ir = 1'b1;
        busy = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (k == 20'd1)      state_nxt = DONE;
        else if (k == 20'd0) state_nxt = ERR;
        else if (timeout)    state_nxt = ERR;
        else if (r)          state_nxt = EVEN;
        else                 state_nxt = ODD;
      end
      EVEN: begin
        Pk = 1'b1;
        Pr = 1'b1;
        Mx = 1'b1;
        busy = 1'b1;
        state_nxt = CHECK;
      end
      ODD: begin
        Ik = 1'b1;
        Mr = 1'b1;
        Mx = 1'b1;
        busy = 1'b1;
        state_nxt = CHECK;
      end
      DONE: begin
        done = 1'b1;
        if (!st) state_nxt = IDLE;
      end
      ERR: begin
        done = 1'b1;
        err = 1'b1;
        if (!st) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_collatz_ctrl.sv
// Bench for collatz_ctrl: a behavioural k/r datapath closes the loop around the controller.
// Expected step counts, latencies and step patterns come from hand-computed Collatz sequences.
module tb_collatz_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0;
  logic [19:0] k;
  logic        r;
  logic        Rx, Mx, Sk, Pk, Ik, Ir, Pr, Mr, busy, done, err;
  logic [19:0] seed_v = 20'd0;

  int n_checks = 0;
  int n_pass = 0;

  collatz_ctrl #(.MAX_STEPS(100)) dut (
    .clk(clk), .rst(rst), .st(st), .k(k), .r(r),
    .Rx(Rx), .Mx(Mx), .Sk(Sk), .Pk(Pk), .Ik(Ik),
    .Ir(Ir), .Pr(Pr), .Mr(Mr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the controller's strobes.
  logic [19:0] k_half, k_odd;
  assign k_half = k >> 1;
  assign k_odd  = 20'(k * 3 + 1);
  always_ff @(posedge clk) begin
    if (Sk) k <= seed_v;
    else if (Pk) k <= k_half;
    else if (Ik) k <= k_odd;
    if (Ir) r <= ~seed_v[0];
    else if (Pr) r <= ~k_half[0];
    else if (Mr) r <= ~k_odd[0];
  end

  typedef struct {
    logic [19:0] seed;
    int          steps;
    logic        exp_err;
    int          lat;
    logic [15:0] pat;
    logic        chk_pat;
  } vec_t;

  typedef struct {
    int          steps;
    logic        exp_err;
    int          lat;
    logic [15:0] pat;
    logic        chk_pat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [10:0] outs();
    return {Rx, Mx, Sk, Pk, Ik, Ir, Pr, Mr, busy, done, err};
  endfunction

  // Runs one seed with a single-cycle st pulse and scores it against the queue head.
  task automatic run_seed(input vec_t v);
    exp_t e;
    int cyc, mx_cnt, viol;
    logic [15:0] pat;
    bit seen_load, seen_done;
    sb.push_back('{v.steps, v.exp_err, v.lat, v.pat, v.chk_pat});
    seed_v = v.seed;
    @(negedge clk);
    st = 1'b1;
    seen_load = 0;
    for (int i = 0; i < 5 && !seen_load; i++) begin
      @(negedge clk);
      if (Rx && Sk && Ir && busy) seen_load = 1;
    end
    st = 1'b0;
    check("load_seen", 32'(seen_load), 32'd1);
    cyc = 0; mx_cnt = 0; viol = 0; pat = '0; seen_done = 0;
    for (int i = 0; i < 2000 && !seen_done; i++) begin
      @(negedge clk);
      cyc++;
      if ((32'(Sk) + 32'(Pk) + 32'(Ik)) > 1 || (32'(Ir) + 32'(Pr) + 32'(Mr)) > 1) viol++;
      if (Mx) begin
        mx_cnt++;
        pat = {pat[14:0], Pk};
      end
      if (done) seen_done = 1;
    end
    e = sb.pop_front();
    check("done_seen", 32'(seen_done), 32'd1);
    check("done_latency", 32'(cyc), 32'(e.lat));
    check("mx_pulses", 32'(mx_cnt), 32'(e.steps));
    check("err_flag", 32'(err), 32'(e.exp_err));
    check("busy_in_done", 32'(busy), 32'd0);
    check("strobe_exclusive", 32'(viol), 32'd0);
    if (e.chk_pat) check("step_pattern", 32'(pat), 32'(e.pat));
    @(negedge clk);
    check("idle_after_done", 32'(outs()), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    bit hit;
    vecs[0] = '{20'd6, 8, 1'b0, 18, 16'h00AF, 1'b1};
    vecs[1] = '{20'd1, 0, 1'b0, 2, 16'h0000, 1'b1};
    vecs[2] = '{20'd0, 0, 1'b1, 2, 16'h0000, 1'b0};
    vecs[3] = '{20'd3, 7, 1'b0, 16, 16'h002F, 1'b1};
    vecs[4] = '{20'd2, 1, 1'b0, 4, 16'h0001, 1'b1};
    vecs[5] = '{20'd7, 16, 1'b0, 34, 16'h0000, 1'b0};
`ifdef COLLATZ_TIMEOUT_EN
    vecs[6] = '{20'd27, 100, 1'b1, 202, 16'h0000, 1'b0};
`else
    vecs[6] = '{20'd27, 111, 1'b0, 224, 16'h0000, 1'b0};
`endif

    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(outs()), 32'd0);

    for (int i = 0; i < 7; i++) run_seed(vecs[i]);

    // Async reset while in EVEN: outputs must clear before the next rising edge.
    seed_v = 20'd6;
    st = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (Pk) hit = 1;
    end
    check("reached_even", 32'(hit), 32'd1);
    st = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset_clear", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_run_after_reset", 32'(outs()), 32'd0);
    run_seed(vecs[0]);

    // st held high through DONE must not restart.
    seed_v = 20'd1;
    @(negedge clk);
    st = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (done) hit = 1;
    end
    check("hold_done_reached", 32'(hit), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done_stays", 32'({done, Rx, busy}), 32'b100);
    end
    st = 1'b0;
    @(negedge clk);
    check("hold_release_idle", 32'(outs()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
